// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: entry layout of the receive FIFO.
// The entry is {parity_error, data}; the width follows the character width.
package uart_pkg;

    localparam int UART_DATA_W_DEF = 8;
    localparam int DATA_LSB        = 0;

    function automatic int entry_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int perr_bit(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x W register array: one synchronous write port and an asynchronous read port.
// Storage is intentionally not reset; the FIFO gates the read data with its valid flag.
module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// UART receive FIFO: edge-detects the receiver done strobe, queues {perr, data}, and
// serves a first-word-fall-through valid/ready read port. Optional afull_o: UART_RX_FIFO_AFULL_EN.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int MAX_UART_DATA_W = UART_DATA_W_DEF,
    parameter int DEPTH           = 16,
    parameter int AFULL_THRESH    = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       rx_done_i,
    input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
    input  logic                       parity_error_i,
    input  logic                       flush_i,
    input  logic                       clr_overflow_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [MAX_UART_DATA_W-1:0] rd_data_o,
    output logic                       rd_perr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       overflow_o
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    output logic                       afull_o
`endif
);

    localparam int EW = entry_w(MAX_UART_DATA_W);
    localparam int PB = perr_bit(MAX_UART_DATA_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // A threshold above DEPTH could never fire; non-power-of-two depth breaks pointer wrap.
    localparam bit CFG_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
                            (AFULL_THRESH >= 0) && (AFULL_THRESH <= DEPTH);
    if (!CFG_OK) begin : g_bad_cfg
        $error("rx_fifo: invalid DEPTH/AFULL_THRESH");
    end

    logic          done_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          ovf_q;
    logic          push, pop, full, wr_en, rd_en, ovf_set;
    logic [EW-1:0] wdata, rdata;

    assign push    = rx_done_i & ~done_q;
    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_valid_o & rd_ready_i;
    assign rd_en   = pop & ~flush_i;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign wr_en   = push & ~flush_i & (~full | pop);
    assign ovf_set = push & ~flush_i & full & ~pop;

    always_comb begin
        count_nxt = count;
        if (flush_i)
            count_nxt = '0;
        else if (wr_en && !rd_en)
            count_nxt = count + 1'b1;
        else if (rd_en && !wr_en)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= rx_done_i;
            count  <= count_nxt;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
                if (ovf_set)
                    ovf_q <= 1'b1;
                else if (clr_overflow_i)
                    ovf_q <= 1'b0;
            end
        end
    end

    assign wdata = {parity_error_i, rx_data_i};

    fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr),
        .wdata_i (wdata),
        .raddr_i (rd_ptr),
        .rdata_o (rdata)
    );

    assign rd_valid_o = (count != '0);
    assign rd_data_o  = rd_valid_o ? rdata[DATA_LSB +: MAX_UART_DATA_W] : '0;
    assign rd_perr_o  = rd_valid_o & rdata[PB];
    assign count_o    = count;
    assign empty_o    = (count == '0);
    assign full_o     = full;
    assign overflow_o = ovf_q;

`ifdef UART_RX_FIFO_AFULL_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) afull_o <= 1'b0;
        else       afull_o <= (count_nxt >= CW'(AFULL_THRESH));
    end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: queue scoreboard of {perr, data}, immediate assertions.
module tb_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, rx_done, perr_in, flush, clr_ovf, rd_ready;
    logic [DW-1:0] rx_data;
    logic          rd_valid, rd_perr, empty, full, overflow;
    logic [DW-1:0] rd_data;
    logic [4:0]    count;
`ifdef UART_RX_FIFO_AFULL_EN
    logic          afull;
`endif

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW:0]   exp_q [$];
    logic          exp_ovf;

    always #5 clk = ~clk;

    rx_fifo #(.MAX_UART_DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(12)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_done_i      (rx_done),
        .rx_data_i      (rx_data),
        .parity_error_i (perr_in),
        .flush_i        (flush),
        .clr_overflow_i (clr_ovf),
        .rd_ready_i     (rd_ready),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .rd_perr_o      (rd_perr),
        .count_o        (count),
        .empty_o        (empty),
        .full_o         (full),
        .overflow_o     (overflow)
`ifdef UART_RX_FIFO_AFULL_EN
        ,
        .afull_o        (afull)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"},    32'(count),    32'(exp_q.size()));
        chk({tag, ".valid"},    32'(rd_valid), 32'(exp_q.size() != 0));
        chk({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
        chk({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // Holds rx_done for `hold` cycles; model accepts the character unless already full.
    task automatic push_char(input logic [DW-1:0] d, input logic p, input int hold);
        @(negedge clk);
        rx_done = 1'b1; rx_data = d; perr_in = p;
        if (exp_q.size() < DEPTH) exp_q.push_back({p, d});
        else                      exp_ovf = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0; rx_data = '0; perr_in = 1'b0;
    endtask

    // Checks the head entry against the scoreboard, then pops it.
    task automatic pop_chk(input string tag);
        logic [DW:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, ".valid"}, 32'(rd_valid), 32'd1);
        chk({tag, ".data"},  32'(rd_data),  32'(e[DW-1:0]));
        chk({tag, ".perr"},  32'(rd_perr),  32'(e[DW]));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_data = '0; perr_in = 1'b0;
        flush = 1'b0; clr_ovf = 1'b0; rd_ready = 1'b0; exp_ovf = 1'b0;
        #12;
        chk_status("reset");
        chk("reset.data", 32'(rd_data), 32'd0);
        chk("reset.perr", 32'(rd_perr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: one long done strobe is one character; empty-read ready is ignored
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk_status("t1.idle");
        push_char(8'h5A, 1'b0, 16);
        @(negedge clk);
        chk_status("t1");
        chk("t1.data", 32'(rd_data), 32'h5A);
        chk("t1.perr", 32'(rd_perr), 32'd0);
        pop_chk("t1.pop");
        chk_status("t1.drained");

        // 2: fill, overflow on the 17th, order preserved
        for (int i = 1; i <= 16; i++) push_char(8'(i), 1'b0, 2);
        @(negedge clk);
        chk_status("t2.filled");
        push_char(8'h11, 1'b0, 3);
        @(negedge clk);
        chk_status("t2.ovf");
        for (int i = 0; i < 16; i++) pop_chk("t2.pop");
        chk_status("t2.drained");
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0; exp_ovf = 1'b0;
        chk_status("t2.clr");

        // 3: full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push_char(8'h40 + 8'(i), 1'b0, 2);
        @(negedge clk);
        chk_status("t3.filled");
        chk("t3.head", 32'(rd_data), 32'h40);
        rx_done = 1'b1; rx_data = 8'h22; rd_ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back({1'b0, 8'h22});
        @(negedge clk);
        rd_ready = 1'b0;
        chk_status("t3.swap");
        repeat (3) @(negedge clk);
        rx_done = 1'b0;
        chk_status("t3.hold");
        for (int i = 0; i < 16; i++) pop_chk("t3.pop");
        chk_status("t3.drained");

        // 4: parity flag travels with its character
        push_char(8'hA5, 1'b1, 4);
        push_char(8'h3C, 1'b0, 4);
        pop_chk("t4.a5");
        pop_chk("t4.3c");

        // 5: flush beats a same-cycle push
        for (int i = 0; i < 5; i++) push_char(8'h60 + 8'(i), 1'b0, 2);
        @(negedge clk);
        flush = 1'b1; rx_done = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        chk_status("t5.flush");
        repeat (3) @(negedge clk);
        rx_done = 1'b0;
        chk_status("t5.after");

        // 6: async reset with entries held
        for (int i = 0; i < 3; i++) push_char(8'h80 + 8'(i), 1'b0, 2);
        @(negedge clk);
        chk("t6.pre.count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        chk_status("t6.rst");
        chk("t6.rst.data", 32'(rd_data), 32'd0);
        chk("t6.rst.perr", 32'(rd_perr), 32'd0);
`ifdef UART_RX_FIFO_AFULL_EN
        chk("t6.rst.afull", 32'(afull), 32'd0);
`endif
        // release reset with a character already in progress: exactly one push
        rx_done = 1'b1; rx_data = 8'h99;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b0, 8'h99});
        @(negedge clk);
        chk_status("t6.midchar");
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        chk_status("t6.midchar.hold");
        for (int i = 0; i < 10; i++) push_char(8'hB0 + 8'(i), 1'b0, 2);
        @(negedge clk);
        chk_status("t6.c11");
`ifdef UART_RX_FIFO_AFULL_EN
        chk("t6.afull11", 32'(afull), 32'd0);
`endif
        push_char(8'hBF, 1'b0, 2);
        @(negedge clk);
        chk_status("t6.c12");
`ifdef UART_RX_FIFO_AFULL_EN
        chk("t6.afull12", 32'(afull), 32'd1);
`endif
        pop_chk("t6.pop99");
        chk_status("t6.c11b");
`ifdef UART_RX_FIFO_AFULL_EN
        chk("t6.afull11b", 32'(afull), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
